// File: rtl/led_pwm_interface.sv
// led_pwm_interface
//
// Bus-attached LED controller. Each of NumLeds channels is either a static
// on/off bit or a PWM-dimmed output gated by its VALUE bit. All PWM channels
// share one prescaled counter.
//
// Register map (byte offsets, only bus_addr[7:2] decoded):
//   0x00 VALUE    [NumLeds-1:0]  static value / PWM gate
//   0x04 MODE     [NumLeds-1:0]  0 = static, 1 = PWM
//   0x08 PRESCALE [15:0]         tick divider (period = PRESCALE+1 cycles)
//   0x0C COUNT    [PwmWidth-1:0] PWM counter, read-only (writes acked, ignored)
//   0x10+4*i      DUTY[i]        [PwmWidth-1:0], i < NumLeds
//   anything else is unmapped and answered with bus_err.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   bus_data_m       write data
//   bus_addr         byte address
//   bus_sel          byte-lane enables for writes
//   bus_cyc/stb/we   cycle, strobe, write enable
//   bus_data_s       registered read data (0 unless bus_ack is high on a read)
//   bus_ack          one-cycle acknowledge for mapped accesses
//   bus_err          one-cycle error for unmapped accesses
//   bus_stall        always 0
//   leds             registered LED drive
//
// Handshake: a request is valid when bus_cyc & bus_stb are both high at a
// rising edge. The slave is always ready (bus_stall = 0), so every valid
// request is accepted at that edge and answered by exactly one of bus_ack or
// bus_err in the following cycle; back-to-back requests get back-to-back
// responses. There is no backpressure in either direction.

module led_pwm_interface #(
  parameter int NumLeds    = 4,
  parameter int PwmWidth   = 8,
  localparam int DataWidth = 32,
  localparam int AddrWidth = 32,
  localparam int SelWidth  = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [DataWidth-1:0] bus_data_s,
  output logic                 bus_ack,
  output logic                 bus_stall,
  output logic                 bus_err,
  input  logic [DataWidth-1:0] bus_data_m,
  input  logic [AddrWidth-1:0] bus_addr,
  input  logic [SelWidth-1:0]  bus_sel,
  input  logic                 bus_cyc,
  input  logic                 bus_stb,
  input  logic                 bus_we,
  output logic [NumLeds-1:0]   leds
);

  localparam logic [5:0] OffValue    = 6'd0;
  localparam logic [5:0] OffMode     = 6'd1;
  localparam logic [5:0] OffPrescale = 6'd2;
  localparam logic [5:0] OffCount    = 6'd3;
  localparam logic [5:0] OffDuty0    = 6'd4;

  // Register state
  logic [NumLeds-1:0]  value_q;
  logic [NumLeds-1:0]  mode_q;
  logic [15:0]         prescale_q;
  logic [PwmWidth-1:0] duty_q [NumLeds];

  // PWM engine state
  logic [15:0]         pre_cnt;
  logic [PwmWidth-1:0] pwm_cnt;
  logic                tick;

  // Bus decode
  logic                 access;
  logic [5:0]           off;
  logic                 mapped;
  logic [DataWidth-1:0] rdata_d;
  logic [DataWidth-1:0] wmerged;
  logic                 wr;
  logic [NumLeds-1:0]   leds_d;

  assign access    = bus_cyc & bus_stb;
  assign off       = bus_addr[7:2];
  assign bus_stall = 1'b0;

  // Read mux doubles as the "old value" of the addressed register for the
  // byte-lane merge below, so one mux serves both directions.
  always_comb begin
    rdata_d = '0;
    mapped  = 1'b0;
    case (off)
      OffValue: begin
        mapped                = 1'b1;
        rdata_d[NumLeds-1:0]  = value_q;
      end
      OffMode: begin
        mapped                = 1'b1;
        rdata_d[NumLeds-1:0]  = mode_q;
      end
      OffPrescale: begin
        mapped                = 1'b1;
        rdata_d[15:0]         = prescale_q;
      end
      OffCount: begin
        mapped                = 1'b1;
        rdata_d[PwmWidth-1:0] = pwm_cnt;
      end
      default: begin
        for (int i = 0; i < NumLeds; i++) begin
          if (off == OffDuty0 + 6'(i)) begin
            mapped                = 1'b1;
            rdata_d[PwmWidth-1:0] = duty_q[i];
          end
        end
      end
    endcase
  end

  // Lanes with bus_sel = 0 keep the current register contents.
  always_comb begin
    wmerged = rdata_d;
    for (int b = 0; b < SelWidth; b++) begin
      if (bus_sel[b]) wmerged[8*b +: 8] = bus_data_m[8*b +: 8];
    end
  end

  assign wr   = access & bus_we & mapped;
  assign tick = (pre_cnt == prescale_q);

  // Register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q    <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      for (int i = 0; i < NumLeds; i++) duty_q[i] <= '0;
    end else if (wr) begin
      if (off == OffValue)    value_q    <= wmerged[NumLeds-1:0];
      if (off == OffMode)     mode_q     <= wmerged[NumLeds-1:0];
      if (off == OffPrescale) prescale_q <= wmerged[15:0];
      for (int i = 0; i < NumLeds; i++) begin
        if (off == OffDuty0 + 6'(i)) duty_q[i] <= wmerged[PwmWidth-1:0];
      end
    end
  end

  // Prescaler and PWM counter. A PRESCALE write restarts the prescaler so the
  // new tick spacing is measured from the write edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (wr && off == OffPrescale) pre_cnt <= '0;
      else if (tick)                pre_cnt <= '0;
      else                          pre_cnt <= pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + PwmWidth'(1);
    end
  end

  // LED drive from current register state (one edge behind a write).
  always_comb begin
    leds_d = '0;
    for (int i = 0; i < NumLeds; i++) begin
      leds_d[i] = mode_q[i] ? (value_q[i] & (pwm_cnt < duty_q[i])) : value_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) leds <= '0;
    else          leds <= leds_d;
  end

  // Bus response: read data is captured before any same-edge write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_ack    <= 1'b0;
      bus_err    <= 1'b0;
      bus_data_s <= '0;
    end else begin
      bus_ack    <= access & mapped;
      bus_err    <= access & ~mapped;
      bus_data_s <= (access & mapped & ~bus_we) ? rdata_d : '0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus_addr[AddrWidth-1:8], bus_addr[1:0], wmerged[DataWidth-1:16]};

endmodule
